// File: rtl/sync_rr_merge_arbiter_pkg.sv
// Shared definitions for the round-robin merge arbiter.
//   state_t   : arbiter FSM encoding (IDLE, ISSUE, WAIT)
//   cnt_width : width of the WAIT-cycle counter for a given TIMEOUT
package sync_rr_merge_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // The counter only has to reach TIMEOUT-1, the value on which the
    // timeout flag is raised.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/sync_rr_merge_arbiter_rr_pick.sv
// Round-robin picker: first set bit of pending at or above ptr, wrapping
// modulo N.
//   pending : request vector
//   ptr     : search start index (< N)
//   valid   : at least one bit of pending is set
//   idx     : winning index
module sync_rr_merge_arbiter_rr_pick #(
    parameter int N    = 9,
    parameter int IDXW = 4
) (
    input  logic [N-1:0]    pending,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    localparam logic [IDXW:0] N_EXT = (IDXW + 1)'(N);

    logic [N-1:0] rot;

    // Rotate so that bit 0 of rot is pending[ptr]; the wrapped copy in the
    // upper half supplies the bits below ptr.
    assign rot = N'({pending, pending} >> ptr);

    always_comb begin
        logic [IDXW:0] sum;
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        // Descending scan so the lowest rotated offset is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IDXW + 1)'(i);
                if (sum >= N_EXT) begin
                    sum = sum - N_EXT;
                end
                idx = sum[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/sync_rr_merge_arbiter.sv
// N-way round-robin arbiter sharing one downstream stage over a drive/free
// handshake. Requests are latched as pending, granted one at a time, and
// released when the shared stage returns its free pulse.
//   clk, rst     : clock, asynchronous active-high reset
//   i_drive[N]   : per-requester drive pulse
//   o_free[N]    : one-hot free pulse back to the grantee
//   o_driveNext  : drive pulse to the shared stage
//   i_freeNext   : free pulse from the shared stage
//   o_sel        : current grantee index (steers the shared stage mux)
//   o_busy       : grant in progress (ISSUE or WAIT)
//   o_err        : sticky protocol error (re-drive while pending/granted)
//   o_timeout    : sticky, WAIT lasted TIMEOUT cycles without a free
module sync_rr_merge_arbiter
    import sync_rr_merge_arbiter_pkg::*;
#(
    parameter int N       = 9,
    parameter int IDXW    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_drive,
    output logic [N-1:0]    o_free,
    output logic            o_driveNext,
    input  logic            i_freeNext,
    output logic [IDXW-1:0] o_sel,
    output logic            o_busy,
    output logic            o_err,
    output logic            o_timeout
);

    localparam int              CNTW     = cnt_width(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDXW:0]   N_EXT    = (IDXW + 1)'(N);
    localparam logic [N-1:0]    ONE      = N'(1);

    state_t            state;
    logic [N-1:0]      pending;
    logic [IDXW-1:0]   ptr;
    logic [CNTW-1:0]   wait_cnt;

    logic              pick_valid;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW:0]     pick_inc;
    logic [N-1:0]      pend_clr;
    logic [N-1:0]      grant_mask;
    logic              grant_now;

    sync_rr_merge_arbiter_rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_rr_pick (
        .pending (pending),
        .ptr     (ptr),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign grant_now  = (state == IDLE) && pick_valid;
    assign pend_clr   = grant_now ? (ONE << pick_idx) : '0;
    assign grant_mask = (state != IDLE) ? (ONE << o_sel) : '0;
    assign pick_inc   = {1'b0, pick_idx} + (IDXW + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            ptr         <= '0;
            wait_cnt    <= '0;
            o_sel       <= '0;
            o_driveNext <= 1'b0;
            o_free      <= '0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_driveNext <= 1'b0;
            o_free      <= '0;

            // A new drive always sets its bit, so it wins over the grant clear.
            pending <= (pending & ~pend_clr) | i_drive;

            // Re-drive from a requester that is still pending or granted.
            if (|(i_drive & (pending | grant_mask))) begin
                o_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        o_sel       <= pick_idx;
                        o_driveNext <= 1'b1;
                        o_busy      <= 1'b1;
                        ptr         <= (pick_inc >= N_EXT) ? '0 : pick_inc[IDXW-1:0];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (i_freeNext) begin
                        o_free   <= ONE << o_sel;
                        o_busy   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        // Saturate; the flag is only a report, the grant is held.
                        if (wait_cnt >= CNT_LAST) begin
                            o_timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
